ins_memory_banked: RTL

INS_MEMORY_BANKED -- requirements
Module: ins_memory_banked

---
 rtl/ins_memory_banked_if.sv | 18 +
 rtl/ins_memory_banked.sv | 68 ++++++
 2 files changed

// File: rtl/ins_memory_banked_if.sv
// ins_memory_banked_if: instruction-fetch block read port plus byte-wide program-load port
// read/address/readdata/busywait carry block reads from the instruction cache;
// prog_write/prog_address/prog_writedata carry single-byte program loads.
interface ins_memory_banked_if #(
  parameter int BLOCK_ADDR_WIDTH = 6,
  parameter int BLOCK_BYTES = 16
);
  localparam int PAW = BLOCK_ADDR_WIDTH + $clog2(BLOCK_BYTES);
  logic read;
  logic [BLOCK_ADDR_WIDTH-1:0] address;
  logic [8*BLOCK_BYTES-1:0] readdata;
  logic busywait;
  logic prog_write;
  logic [PAW-1:0] prog_address;
  logic [7:0] prog_writedata;
  modport master (output read, address, prog_write, prog_address, prog_writedata, input readdata, busywait);
  modport slave (input read, address, prog_write, prog_address, prog_writedata, output readdata, busywait);
endinterface

// File: rtl/ins_memory_banked.sv
// ins_memory_banked: byte-organised instruction memory returning whole blocks after a fixed latency
// clk: rising-edge clock; rst: asynchronous active-high reset
// bus (slave): read/address request, readdata/busywait response, prog_* byte loader
module ins_memory_banked #(
  parameter int BLOCK_ADDR_WIDTH = 6,
  parameter int BLOCK_BYTES = 16,
  parameter int LATENCY = 5
) (
  input logic clk,
  input logic rst,
  ins_memory_banked_if.slave bus
);
  localparam int OW = $clog2(BLOCK_BYTES);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int BW = 8 * BLOCK_BYTES;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BLOCK_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0] rd_q, rd_d, blk;
  logic we;
  logic [7:0] mem [(2**BLOCK_ADDR_WIDTH)*BLOCK_BYTES];
  for (genvar i = 0; i < BLOCK_BYTES; i++) begin : g_byte
    assign blk[8*i +: 8] = mem[{addr_q, OW'(i)}];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    rd_d = rd_q;
    we = 1'b0;
    case (state_q)
      IDLE: begin
        we = bus.prog_write & ~bus.read;
        if (bus.read) begin
          state_d = BUSY;
          cnt_d = CW'(LATENCY - 1);
          addr_d = bus.address;
        end
      end
      BUSY: begin
        cnt_d = cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
        rd_d = cnt_q == '0 ? blk : rd_q;
        state_d = cnt_q == '0 ? DONE : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
    end
  end
  // storage is deliberately outside the reset domain so a reset never wipes a loaded program
  always_ff @(posedge clk) begin
    if (we) mem[bus.prog_address] <= bus.prog_writedata;
  end
  assign bus.readdata = rd_q;
  assign bus.busywait = ~rst & ((state_q == IDLE & bus.read) | state_q == BUSY);
endmodule
